// File: rtl/mux3_arb_pkg.sv
// mux3_arb_pkg: shared source encodings and default widths for the round-robin arbiter
package mux3_arb_pkg;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    localparam int   DEF_W     = 3;
    localparam int   DEF_CNT_W = 8;
endpackage

// File: rtl/arb_mux_3b.sv
// arb_mux_3b: combinational W-bit 2:1 select; ports a_i/b_i data, sel_i (0=A, 1=B), y_o result
module arb_mux_3b #(
    parameter int W = 3
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin arbiter of two valid/ready requesters into a single-entry output register.
// Ports: clk, rst (sync, active-high); a_valid/a_data/a_ready and b_valid/b_data/b_ready requester
// handshakes; out_valid/out_data/out_src/out_ready output handshake (out_src 0=A, 1=B);
// cnt_a/cnt_b saturating grant counters, present only when MUX3_ARB_STATS_EN is defined.
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [W-1:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [W-1:0]     b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_src,
    input  logic             out_ready
`ifdef MUX3_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_src_q, out_src_d;
    logic         last_q, last_d;
    logic         grant, can_load, accept;
    logic [W-1:0] mux_data;

    // On a tie the requester that did not win last time gets the grant.
    assign grant    = (a_valid & b_valid) ? ~last_q : b_valid;
    // Gated by rst so no handshake completes in a reset cycle.
    assign can_load = ~rst & (~out_valid_q | out_ready);
    assign accept   = can_load & (a_valid | b_valid);
    assign a_ready  = can_load & a_valid & (grant == SRC_A);
    assign b_ready  = can_load & b_valid & (grant == SRC_B);

    arb_mux_3b #(.W(W)) u_mux (
        .a_i   (a_data),
        .b_i   (b_data),
        .sel_i (grant),
        .y_o   (mux_data)
    );

    always_comb begin
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? mux_data : out_data_q;
        out_src_d   = accept ? grant : out_src_q;
        last_d      = accept ? grant : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_A;
            last_q      <= SRC_B;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef MUX3_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = (a_ready && cnt_a_q != '1) ? cnt_a_q + 1'b1 : cnt_a_q;
        cnt_b_d = (b_ready && cnt_b_q != '1) ? cnt_b_q + 1'b1 : cnt_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif
endmodule
